// File: rtl/i2s_sched.sv
// Two-requester round-robin sample FIFO feeding an I2S serializer.
// Playback starts once PRIME samples are queued; an empty pop flags a sticky underrun.
module i2s_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PRIME = 2
) (
  input  logic                     clk,
  input  logic                     resetq,
  input  logic                     a_valid,
  input  logic [15:0]              a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [15:0]              b_data,
  output logic                     b_ready,
  input  logic                     frame_tick,
  output logic [15:0]              value,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     playing,
  output logic                     underrun,
  input  logic                     underrun_clr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] DepthLv = LW'(DEPTH);
  localparam logic [LW-1:0] PrimeLv = LW'(PRIME);
  localparam logic [LW-1:0] LvOne   = LW'(1);
  localparam logic [PW-1:0] PtrOne  = PW'(1);

  typedef enum logic [0:0] {StFill, StPlay} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     value_q, value_d;
  logic            underrun_q, underrun_d;
  logic            last_b_q, last_b_d;
  logic [15:0]     mem_q [DEPTH];

  logic            space;
  logic            grant_a, grant_b, wr;
  logic [15:0]     wdata;
  logic            pop, under_evt;

  // Space uses the registered level only, so a same-cycle pop never frees a slot.
  assign space   = resetq && (level_q < DepthLv);
  assign grant_a = space && a_valid && (!b_valid || last_b_q);
  assign grant_b = space && b_valid && (!a_valid || !last_b_q);
  assign wr      = grant_a || grant_b;
  assign wdata   = grant_a ? a_data : b_data;

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign value    = value_q;
  assign level    = level_q;
  assign underrun = underrun_q;

  // FSM state register
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: if (level_q >= PrimeLv) state_d = StPlay;
      StPlay: if (frame_tick && (level_q == '0)) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // FSM outputs
  always_comb begin
    playing   = 1'b0;
    pop       = 1'b0;
    under_evt = 1'b0;
    unique case (state_q)
      StFill: ;
      StPlay: begin
        playing   = 1'b1;
        pop       = frame_tick && (level_q != '0);
        under_evt = frame_tick && (level_q == '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    level_d    = level_q;
    value_d    = value_q;
    underrun_d = underrun_q;
    last_b_d   = last_b_q;
    if (wr) tail_d = tail_q + PtrOne;
    if (pop) begin
      head_d  = head_q + PtrOne;
      value_d = mem_q[head_q];
    end else if (under_evt) begin
      value_d = 16'h0000;
    end
    if (wr && !pop) begin
      level_d = level_q + LvOne;
    end else if (!wr && pop) begin
      level_d = level_q - LvOne;
    end
    if (under_evt) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
    if (grant_a) begin
      last_b_d = 1'b0;
    end else if (grant_b) begin
      last_b_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      head_q     <= '0;
      tail_q     <= '0;
      level_q    <= '0;
      value_q    <= 16'h0000;
      underrun_q <= 1'b0;
      last_b_q   <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      level_q    <= level_d;
      value_q    <= value_d;
      underrun_q <= underrun_d;
      last_b_q   <= last_b_d;
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (wr) mem_q[tail_q] <= wdata;
  end

endmodule

// File: doc/i2s_sched.md
I2S_SCHED -- requirements
Module: i2s_sched

Interface
- REQ-001 Parameter DEPTH, default 4: sample FIFO depth in entries; power of two, 2..16.
- REQ-002 Parameter PRIME, default 2: FIFO level required before playback starts; 1..DEPTH.
- REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
- REQ-004 Port resetq, input, 1: reset, asynchronous, active-low.
- REQ-005 Port a_valid, input, 1: requester A offers a sample.
- REQ-006 Port a_data, input, 16: requester A sample.
- REQ-007 Port a_ready, output, 1: requester A sample accepted this cycle.
- REQ-008 Port b_valid, input, 1: requester B offers a sample.
- REQ-009 Port b_data, input, 16: requester B sample.
- REQ-010 Port b_ready, output, 1: requester B sample accepted this cycle.
- REQ-011 Port frame_tick, input, 1: one-cycle pulse at the serializer frame boundary, when the serializer latches value.
- REQ-012 Port value, output, 16: registered sample driven to the I2S serializer value input.
- REQ-013 Port level, output, $clog2(DEPTH)+1: registered FIFO occupancy.
- REQ-014 Port playing, output, 1: high in state PLAY.
- REQ-015 Port underrun, output, 1: sticky underrun flag.
- REQ-016 Port underrun_clr, input, 1: clears underrun.

Function
- REQ-017 Arbitration: there is space when level < DEPTH, using the registered level; a pop in the same cycle does not free space.
- REQ-018 Arbitration: with space and exactly one requester valid, that requester is granted.
- REQ-019 Arbitration: with space and both requesters valid, grant the requester not granted last (round-robin); the last-grant bit resets to B, so A wins the first tie.
- REQ-020 Ready rules: a_ready/b_ready are combinational, at most one high per cycle, and never high without the matching valid.
- REQ-021 Ready rules: when full, both are low.
- REQ-022 Write: a granted sample is written at the FIFO tail on the clock edge; the tail pointer wraps modulo DEPTH.
- REQ-023 FSM has two states, FILL and PLAY; it resets to FILL.
- REQ-024 FILL: frame_tick does not pop and value is held at 16'h0000.
- REQ-025 FILL -> PLAY on the edge where the registered level >= PRIME; the first pop occurs on the next frame_tick after entering PLAY.
- REQ-026 PLAY, frame_tick with level > 0: value <= FIFO head on that edge, the head pointer advances modulo DEPTH, and level decrements.
- REQ-027 PLAY, frame_tick with level == 0: value <= 16'h0000, underrun <= 1, next state FILL.
- REQ-028 PLAY without frame_tick: value holds.
- REQ-029 Simultaneous write and pop in one cycle: both take effect and level is unchanged.
- REQ-030 Level always stays within 0..DEPTH; data order is strict FIFO across both requesters.
- REQ-031 underrun_clr clears underrun; if it coincides with a new underrun event, set wins.
- REQ-032 Latency: a sample written at edge N is visible on value no earlier than the first frame_tick edge after N.

Reset
- REQ-033 resetq low asynchronously forces: value=0, level=0, head/tail pointers=0, state FILL, playing=0, underrun=0, last-grant=B.
- REQ-034 While resetq is low, a_ready=b_ready=0 and the FIFO contents are discarded.
- REQ-035 Reset asserted mid-operation, including mid-PLAY, discards all queued samples.
- REQ-036 Normal operation resumes on the first clk edge after resetq deasserts.

Verification
- REQ-037 A-only priming: A writes 16'haa00, then 16'h5500, with ticks every 32 cycles -> playing rises after the second write; value = aa00 after the next tick, then 5500 after the following tick.
- REQ-038 Round-robin tie: A and B both held valid with data A=1111, B=2222, no ticks -> accept order A, B, A, B; level=4; both readies then low.
- REQ-039 Full plus pop: level=4 with tick and A valid in the same cycle -> A not accepted that cycle; level=3, then A accepted the next cycle, level=4.
- REQ-040 Underrun: PLAY with level=1, two ticks and no writes -> value = head, then 0000; underrun=1; playing=0; underrun_clr pulse -> underrun=0.
- REQ-041 Simultaneous write and pop: PLAY, level=2, tick and B write in the same cycle -> level stays 2 and FIFO order is preserved.
- REQ-042 Async reset: resetq pulled low between edges in PLAY with level=3 -> all outputs are at reset values immediately; after release, value stays 0000 until re-primed.
